// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter and its legality checker.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned REQ_ADDR_W = 32;

  typedef enum logic [0:0] {IDLE, ACCESS} state_t;

  typedef struct packed {
    logic                  we;
    logic [2:0]            funct3;
    logic [REQ_ADDR_W-1:0] addr;
    logic [31:0]           wdata;
  } mem_req_t;

  // Access width in bytes encoded by funct3[1:0].
  function automatic logic [2:0] access_size(logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/dmem_access_check.sv
// Combinational legality check of a load/store: funct3, alignment and bounds.
module dmem_access_check
  import dmem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 128,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              we,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  output logic              legal
);

  localparam int unsigned EW = ADDR_W + 1;

  logic          f3_ok;
  logic          align_ok;
  logic          bound_ok;
  logic [EW-1:0] end_addr;

  always_comb begin
    f3_ok    = 1'b0;
    align_ok = 1'b1;
    case (funct3)
      F3_B, F3_H, F3_W: f3_ok = 1'b1;
      F3_BU, F3_HU:     f3_ok = !we;
      default:          f3_ok = 1'b0;
    endcase
    case (funct3)
      F3_H, F3_HU: align_ok = !addr[0];
      F3_W:        align_ok = (addr[1:0] == 2'b00);
      default:     align_ok = 1'b1;
    endcase
    // One extra bit so addr + size cannot wrap past the top of the address space.
    end_addr = {1'b0, addr} + EW'(access_size(funct3));
    bound_ok = (end_addr <= EW'(MEM_BYTES));
    legal    = f3_ok & align_ok & bound_ok;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin two-requester arbiter and one-cycle sequencer for the data memory.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 128,
  parameter int unsigned ADDR_W    = REQ_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic              r0_we,
  input  logic [2:0]        r0_funct3,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [31:0]       r0_wdata,
  output logic              r0_rsp_valid,
  output logic [31:0]       r0_rsp_rdata,
  output logic              r0_rsp_err,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic              r1_we,
  input  logic [2:0]        r1_funct3,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [31:0]       r1_wdata,
  output logic              r1_rsp_valid,
  output logic [31:0]       r1_rsp_rdata,
  output logic              r1_rsp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [2:0]        mem_funct3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_t   state_q;
  logic     last_grant_q;
  logic     gid_q;
  mem_req_t req_q;
  mem_req_t sel_req;
  logic     grant_id;
  logic     hs;
  logic     legal;
  logic     in_access;

  always_comb begin
    // On contention the requester that did not win last time is preferred.
    grant_id = (r0_valid & r1_valid) ? ~last_grant_q : r1_valid;
    r0_ready = !rst && (state_q == IDLE) && r0_valid && !grant_id;
    r1_ready = !rst && (state_q == IDLE) && r1_valid && grant_id;
    hs       = r0_ready | r1_ready;

    sel_req.we     = grant_id ? r1_we     : r0_we;
    sel_req.funct3 = grant_id ? r1_funct3 : r0_funct3;
    sel_req.addr   = grant_id ? r1_addr   : r0_addr;
    sel_req.wdata  = grant_id ? r1_wdata  : r0_wdata;
  end

  dmem_access_check #(
    .MEM_BYTES(MEM_BYTES),
    .ADDR_W   (ADDR_W)
  ) u_check (
    .we    (req_q.we),
    .funct3(req_q.funct3),
    .addr  (req_q.addr),
    .legal (legal)
  );

  always_comb begin
    in_access  = !rst && (state_q == ACCESS);
    mem_read   = in_access && legal && !req_q.we;
    mem_write  = in_access && legal && req_q.we;
    mem_funct3 = req_q.funct3;
    mem_addr   = req_q.addr;
    mem_wdata  = req_q.wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      gid_q        <= 1'b0;
      req_q        <= '0;
      r0_rsp_valid <= 1'b0;
      r0_rsp_rdata <= '0;
      r0_rsp_err   <= 1'b0;
      r1_rsp_valid <= 1'b0;
      r1_rsp_rdata <= '0;
      r1_rsp_err   <= 1'b0;
    end else begin
      r0_rsp_valid <= 1'b0;
      r1_rsp_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (hs) begin
            req_q        <= sel_req;
            gid_q        <= grant_id;
            last_grant_q <= grant_id;
            state_q      <= ACCESS;
          end
        end
        ACCESS: begin
          if (gid_q) begin
            r1_rsp_valid <= 1'b1;
            r1_rsp_rdata <= (legal && !req_q.we) ? mem_rdata : 32'h0;
            r1_rsp_err   <= !legal;
          end else begin
            r0_rsp_valid <= 1'b1;
            r0_rsp_rdata <= (legal && !req_q.we) ? mem_rdata : 32'h0;
            r0_rsp_err   <= !legal;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
